// File: rtl/ps2_scan_seq.sv
// ps2_scan_seq: turns PS/2 receiver bytes into key events held in a small show-ahead FIFO.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses auto-repeated makes of the last key pressed.
module ps2_scan_seq #(
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX_VALID,
    input  logic [7:0] RX_DATA,
    input  logic       RX_ERR,
    output logic       RX_FLUSH,
    output logic       EV_VALID,
    input  logic       EV_READY,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic [1:0] KB_STATUS,
    output logic [7:0] ERR_CNT,
    output logic [3:0] ARROW_STATE
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP} state_t;

    state_t          state, state_nxt;
    logic [2:0]      skip, skip_nxt;
    logic [TW-1:0]   tmo;
    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      dec_code;
    logic [3:0]      arrow_mask, arrow_nxt;
    logic            good, bad, expire, dec_push, dec_ext, dec_brk, bat_ok, bat_fail, ovr;
    logic            want, push, pop, full, drop, err_inc;

    assign good   = RX_VALID && !RX_ERR;
    assign bad    = RX_VALID && RX_ERR;
    assign expire = state != IDLE && !RX_VALID && tmo == TW'(TIMEOUT_CYC - 1);

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        dec_push  = 1'b0;
        dec_ext   = 1'b0;
        dec_brk   = 1'b0;
        dec_code  = RX_DATA;
        bat_ok    = 1'b0;
        bat_fail  = 1'b0;
        ovr       = 1'b0;
        if (bad || expire)
            state_nxt = IDLE;
        else if (good)
            case (state)
                IDLE:
                    case (RX_DATA)
                        8'hAA: bat_ok = 1'b1;
                        8'hFC: bat_fail = 1'b1;
                        8'hE0: state_nxt = GOT_E0;
                        8'hF0: state_nxt = GOT_F0;
                        8'hE1: begin
                            state_nxt = SKIP;
                            skip_nxt  = 3'd7;
                        end
                        8'h00, 8'hFF: ovr = 1'b1;
                        default: dec_push = 1'b1;
                    endcase
                GOT_E0:
                    if (RX_DATA == 8'hF0)
                        state_nxt = GOT_E0F0;
                    else if (RX_DATA != 8'hE0) begin
                        dec_push  = 1'b1;
                        dec_ext   = 1'b1;
                        state_nxt = IDLE;
                    end
                GOT_F0: begin
                    dec_push  = 1'b1;
                    dec_brk   = 1'b1;
                    state_nxt = IDLE;
                end
                GOT_E0F0: begin
                    dec_push  = 1'b1;
                    dec_ext   = 1'b1;
                    dec_brk   = 1'b1;
                    state_nxt = IDLE;
                end
                SKIP:
                    if (skip == 3'd1) begin
                        dec_push  = 1'b1;
                        dec_code  = 8'hE1;
                        state_nxt = IDLE;
                    end else
                        skip_nxt = skip - 3'd1;
                default: state_nxt = IDLE;
            endcase
    end

    assign arrow_mask = {dec_code == 8'h75, dec_code == 8'h72, dec_code == 8'h6B, dec_code == 8'h74};
    assign arrow_nxt  = (bat_ok || bat_fail) ? 4'b0000 :
                        (dec_push && dec_ext) ? (dec_brk ? ARROW_STATE & ~arrow_mask : ARROW_STATE | arrow_mask) :
                        ARROW_STATE;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last;
    logic       last_v, is_key, rep;

    // Pause is synthesised from SKIP, not a real key, so it never enters the filter.
    assign is_key = dec_push && state != SKIP;
    assign rep    = is_key && !dec_brk && last_v && last == {dec_ext, dec_code};
    assign want   = dec_push && !rep;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last   <= '0;
            last_v <= 1'b0;
        end else if (bad || bat_ok || bat_fail)
            last_v <= 1'b0;
        else if (is_key && !dec_brk) begin
            last   <= {dec_ext, dec_code};
            last_v <= 1'b1;
        end else if (is_key && last == {dec_ext, dec_code})
            last_v <= 1'b0;
    end
`else
    assign want = dec_push;
`endif

    assign EV_VALID = count != '0;
    assign full     = count == CW'(FIFO_DEPTH);
    assign pop      = EV_VALID && EV_READY;
    assign push     = want && (!full || pop);
    assign drop     = want && full && !pop;
    assign err_inc  = bad || expire || ovr || drop;
    assign {EV_EXT, EV_BREAK, EV_CODE} = EV_VALID ? mem[rd_ptr] : 10'd0;

    always_ff @(posedge CLK)
        if (push)
            mem[wr_ptr] <= {dec_ext, dec_brk, dec_code};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            skip        <= '0;
            tmo         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            RX_FLUSH    <= 1'b0;
            KB_STATUS   <= 2'b00;
            ERR_CNT     <= 8'd0;
            ARROW_STATE <= 4'b0000;
        end else begin
            state       <= state_nxt;
            skip        <= skip_nxt;
            tmo         <= (RX_VALID || expire || state == IDLE) ? '0 : tmo + 1'b1;
            rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
            count       <= count + CW'(push) - CW'(pop);
            RX_FLUSH    <= bad || expire;
            KB_STATUS   <= bat_ok ? 2'b01 : bat_fail ? 2'b10 : KB_STATUS;
            ERR_CNT     <= (err_inc && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
            ARROW_STATE <= arrow_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_scan_seq.sv
// tb_ps2_scan_seq: table-driven byte vectors plus hand sequences for timeout, overflow and mid-sequence reset.
module tb_ps2_scan_seq;
    localparam int TMO = 40;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       CLK = 1'b0, RST_N, RX_VALID, RX_ERR, RX_FLUSH, EV_VALID, EV_READY, EV_EXT, EV_BREAK;
    logic [7:0] RX_DATA, EV_CODE, ERR_CNT;
    logic [1:0] KB_STATUS;
    logic [3:0] ARROW_STATE;
    int checks = 0, failures = 0;

    ps2_scan_seq #(.TIMEOUT_CYC(TMO), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_ERR(RX_ERR),
        .RX_FLUSH(RX_FLUSH), .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_CODE(EV_CODE),
        .EV_EXT(EV_EXT), .EV_BREAK(EV_BREAK), .KB_STATUS(KB_STATUS), .ERR_CNT(ERR_CNT),
        .ARROW_STATE(ARROW_STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       e;
        logic       v;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] arrow;
        logic [7:0] errc;
        logic       fl;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        @(negedge CLK);
        RX_VALID = 1'b1;
        RX_DATA  = d;
        RX_ERR   = e;
        @(negedge CLK);
        RX_VALID = 1'b0;
        RX_ERR   = 1'b0;
    endtask

    function automatic logic [25:0] outs();
        return {EV_VALID, EV_CODE, EV_EXT, EV_BREAK, ARROW_STATE, ERR_CNT, RX_FLUSH, KB_STATUS};
    endfunction

    initial begin
        logic [7:0] ov[5];
        int fl_cnt;
        ov = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        //             d     e  v  code   x  b  arrow    errc  fl st
        tbl.push_back('{8'hAA, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'h1C, 0, 1, 8'h1C, 0, 0, 4'b0000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'hE0, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'h75, 0, 1, 8'h75, 1, 0, 4'b1000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'hE0, 0, 0, 8'h00, 0, 0, 4'b1000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 8'h00, 0, 0, 4'b1000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'h75, 0, 1, 8'h75, 1, 1, 4'b0000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'h1C, 0, 1, 8'h1C, 0, 1, 4'b0000, 8'd0, 0, 2'b01});
        tbl.push_back('{8'h55, 1, 0, 8'h00, 0, 0, 4'b0000, 8'd1, 1, 2'b01});
        tbl.push_back('{8'h16, 0, 1, 8'h16, 0, 0, 4'b0000, 8'd1, 0, 2'b01});
        tbl.push_back('{8'h75, 0, 1, 8'h75, 0, 0, 4'b0000, 8'd1, 0, 2'b01});
        tbl.push_back('{8'hE0, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd1, 0, 2'b01});
        tbl.push_back('{8'h6B, 0, 1, 8'h6B, 1, 0, 4'b0010, 8'd1, 0, 2'b01});
        tbl.push_back('{8'h00, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hE1, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h14, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h77, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hE1, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h14, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h77, 0, 1, 8'hE1, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hE0, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 8'h00, 0, 0, 4'b0010, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h6B, 0, 1, 8'h6B, 1, 1, 4'b0000, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hE0, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h74, 0, 1, 8'h74, 1, 0, 4'b0001, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hFC, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd2, 0, 2'b10});
        tbl.push_back('{8'hAA, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h1C, 0, 1, 8'h1C, 0, 0, 4'b0000, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h1C, 0, !FILT, FILT ? 8'h00 : 8'h1C, 0, 0, 4'b0000, 8'd2, 0, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 8'h00, 0, 0, 4'b0000, 8'd2, 0, 2'b01});
        tbl.push_back('{8'h1C, 0, 1, 8'h1C, 0, 1, 4'b0000, 8'd2, 0, 2'b01});

        RST_N = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00; RX_ERR = 1'b0; EV_READY = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_held", 64'(outs()), 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("reset_released", 64'(outs()), 64'd0);

        foreach (tbl[i]) begin
            send(tbl[i].d, tbl[i].e);
            chk($sformatf("vec%0d_byte%h", i, tbl[i].d), 64'(outs()),
                64'({tbl[i].v, tbl[i].code, tbl[i].ext, tbl[i].brk, tbl[i].arrow, tbl[i].errc, tbl[i].fl, tbl[i].st}));
            @(negedge CLK);
            chk($sformatf("vec%0d_drained", i), 64'({EV_VALID, RX_FLUSH}), 64'd0);
        end

        send(8'hE0, 1'b0);
        fl_cnt = 0;
        for (int c = 0; c < TMO + 10; c++) begin
            @(negedge CLK);
            if (RX_FLUSH) fl_cnt++;
        end
        chk("timeout_flush_pulses", 64'(fl_cnt), 64'd1);
        chk("timeout_err_cnt", 64'(ERR_CNT), 64'd3);
        send(8'h16, 1'b0);
        chk("timeout_next_event", 64'({EV_VALID, EV_CODE, EV_EXT, EV_BREAK}), 64'({1'b1, 8'h16, 1'b0, 1'b0}));
        @(negedge CLK);

        EV_READY = 1'b0;
        foreach (ov[i]) send(ov[i], 1'b0);
        chk("overflow_err_cnt", 64'(ERR_CNT), 64'd4);
        EV_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("overflow_pop%0d", k), 64'({EV_VALID, EV_CODE, EV_EXT, EV_BREAK}), 64'({1'b1, ov[k], 2'b00}));
            @(negedge CLK);
        end
        chk("overflow_empty", 64'(EV_VALID), 64'd0);

        EV_READY = 1'b0;
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        chk("midreset_pre_valid", 64'(EV_VALID), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("midreset_cleared", 64'(outs()), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        EV_READY = 1'b1;
        send(8'h75, 1'b0);
        chk("midreset_prefix_lost", 64'({EV_VALID, EV_CODE, EV_EXT, EV_BREAK, ARROW_STATE}), 64'({1'b1, 8'h75, 2'b00, 4'b0000}));
        @(negedge CLK);
        chk("midreset_single_event", 64'(EV_VALID), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_scan_seq.md
Name: ps2_scan_seq

Overview:
- Sequences the byte stream from the PS/2 frame receiver into key events.
- Tracks E0 (extended), F0 (break) and E1 (pause) prefixes and BAT status codes (AA/FC).
- Flushes the receiver on parity errors or a stalled multi-byte sequence.
- Buffers decoded events in a small FIFO for downstream consumers (display/LED logic), and keeps live arrow-key state.

Parameters:
- TIMEOUT_CYC, 20000: CLK cycles allowed between bytes of a multi-byte sequence before it is abandoned.
- FIFO_DEPTH, 4: event FIFO entries; power of 2, minimum 2.

Ports:
- CLK  in  1  system clock; the single clock.
- RST_N  in  1  asynchronous active-low reset.
- RX_VALID  in  1  one-cycle strobe: a frame byte is available.
- RX_DATA  in  8  received byte; valid with RX_VALID.
- RX_ERR  in  1  parity/start/stop error for this frame; valid with RX_VALID.
- RX_FLUSH  out  1  one-cycle pulse telling the receiver to discard any partial frame.
- EV_VALID  out  1  FIFO non-empty; an event is presented.
- EV_READY  in  1  consumer accepts the event.
- EV_CODE  out  8  scan code of the event.
- EV_EXT  out  1  event was E0-prefixed.
- EV_BREAK  out  1  key release.
- KB_STATUS  out  2  00 unknown, 01 BAT ok (AA), 10 BAT fail (FC).
- ERR_CNT  out  8  saturating error counter.
- ARROW_STATE  out  4  {up,down,left,right} currently held.

Behaviour:
- Reset: every output is 0 (RX_FLUSH, EV_VALID, EV_CODE, EV_EXT, EV_BREAK, KB_STATUS, ERR_CNT, ARROW_STATE). FSM goes to IDLE; FIFO is empty; timeout counter is 0.
- Reset asserted mid-sequence discards the FIFO contents and any partial prefix.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP. Transitions act only on RX_VALID with RX_ERR=0.
- IDLE:
  - AA → KB_STATUS=01, ARROW_STATE=0.
  - FC → KB_STATUS=10, ARROW_STATE=0.
  - E0 → GOT_E0.
  - F0 → GOT_F0.
  - E1 → SKIP, skip count=7.
  - 00 or FF (keyboard overrun) → ERR_CNT+1, no event.
  - Any other byte → push {code,ext=0,brk=0}.
- GOT_E0: F0 → GOT_E0F0; E0 → stay; any other byte → push {code,1,0}, then IDLE.
- GOT_F0: any byte → push {code,0,1}, then IDLE.
- GOT_E0F0: any byte → push {code,1,1}, then IDLE.
- SKIP: each byte decrements the skip count. When the count reaches 0, push {E1,0,0} (Pause) and go to IDLE. Bytes inside SKIP are never decoded, including AA/F0.
- RX_ERR=1 with RX_VALID:
  - Byte discarded; ERR_CNT+1.
  - RX_FLUSH pulses on the next cycle.
  - FSM → IDLE from any state.
- Timeout:
  - Counter runs in any state other than IDLE and clears on every RX_VALID.
  - When it reaches TIMEOUT_CYC-1: FSM → IDLE, RX_FLUSH pulse, ERR_CNT+1.
  - RX_VALID on the same cycle as expiry: the byte wins and the timeout is ignored.
- ERR_CNT saturates at FF. Concurrent error sources in one cycle count once.
- FIFO:
  - Show-ahead. RX_VALID in cycle n into an empty FIFO gives EV_VALID=1 in cycle n+1.
  - Pop when EV_VALID&&EV_READY.
  - Full and no pop: the new event is dropped, ERR_CNT+1.
  - Full with pop in the same cycle: push is accepted and the occupancy is unchanged.
  - Push and pop in the same cycle on an empty FIFO is not possible (EV_VALID=0).
  - Pointers wrap modulo FIFO_DEPTH.
- ARROW_STATE: updated at decode, independent of FIFO space.
  - Ext make 75/72/6B/74 sets up/down/left/right; the matching ext break clears it.
  - Non-ext codes 75/72/6B/74 do not touch ARROW_STATE.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A register holds the {ext,code} of the last pushed make, plus a valid bit.
  - A make matching it while valid is not pushed (auto-repeat suppressed); ARROW_STATE is unaffected.
  - A break matching it clears the valid bit. A different make replaces it.
  - BAT codes and RX errors clear it.
- Undefined: every make is pushed, including typematic repeats.

Test Plan:
- Reset release, bytes AA then 1C (EV_READY=1) → KB_STATUS=01; one event {1C,0,0}; EV_VALID high exactly one cycle, starting the cycle after the 1C strobe.
- E0 75, then E0 F0 75 → events {75,1,0} and {75,1,1}; ARROW_STATE=1000 after the make, 0000 after the break.
- F0 1C, then a byte with RX_ERR=1, then 16 → events {1C,0,1} and {16,0,0}; RX_FLUSH pulses once; ERR_CNT=1.
- E0, then no byte for TIMEOUT_CYC cycles, then 16 → RX_FLUSH pulse, ERR_CNT=1, event {16,0,0} (not extended).
- EV_READY=0, push 5 makes with FIFO_DEPTH=4 → first 4 retained in order, 5th dropped, ERR_CNT=1. Then EV_READY=1 → 4 pops, EV_VALID falls.
- E1 + 7 arbitrary bytes (including F0) → a single event {E1,0,0}, ERR_CNT unchanged. With PS2_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0 1C → events {1C,0,0} and {1C,0,1} only.
